// File: rtl/sin_cos_pkg.sv
// Shared constants for the sin/cos and phase/magnitude CORDIC blocks.
// Angles are in turns; the ATAN table is scaled to 2^24 per turn.
package sin_cos_pkg;

  localparam int ATAN_W = 24;

  localparam logic [23:0] ATAN_TAB [16] = '{
    24'd2097152, 24'd1238021, 24'd654136, 24'd332050,
    24'd166669,  24'd83416,   24'd41718,  24'd20860,
    24'd10430,   24'd5215,    24'd2608,   24'd1304,
    24'd652,     24'd326,     24'd163,    24'd81
  };

  localparam int K_INV = 1244;

  localparam logic [15:0] TURN_HALF    = 16'd1024;
  localparam logic [15:0] TURN_QUARTER = 16'd512;
  localparam logic [15:0] PHASE_MASK   = 16'h07FF;

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    DONE
  } state_e;

  // ATAN[i] rescaled from 2^24 to 2^aw units per turn
  function automatic logic [31:0] atan_at(
    input logic [3:0] i,
    input int         aw
  );
    logic [31:0] t;
    t = {8'd0, ATAN_TAB[i]};
    if (aw >= ATAN_W) begin
      atan_at = t << (aw - ATAN_W);
    end else begin
      atan_at = (t + (32'd1 << (ATAN_W - 1 - aw)))
                >> (ATAN_W - aw);
    end
  endfunction

endpackage

// File: rtl/phase_mag_unit_stage.sv
// One vectoring-mode CORDIC micro-rotation, purely combinational.
// Drives y toward zero and accumulates the rotated angle into z.
module cordic_vec_stage
  import sin_cos_pkg::*;
#(
  parameter int DW = 24,
  parameter int AW = 24
) (
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] y_i,
  input  logic        [AW-1:0] z_i,
  input  logic        [3:0]    i_i,
  output logic signed [DW-1:0] x_o,
  output logic signed [DW-1:0] y_o,
  output logic        [AW-1:0] z_o
);

  logic signed [DW-1:0] xs;
  logic signed [DW-1:0] ys;
  logic        [AW-1:0] at;

  // rotate against the sign of y using the pre-update x/y
  always_comb begin
    xs = x_i >>> i_i;
    ys = y_i >>> i_i;
    at = AW'(atan_at(i_i, AW));
    if (!y_i[DW-1]) begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + at;
    end else begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - at;
    end
  end

endmodule

// File: rtl/phase_mag_unit.sv
// Iterative vectoring CORDIC: (x, y) -> phase in turns and magnitude.
// One micro-rotation per clock through a single reused stage.
module phase_mag_unit
  import sin_cos_pkg::*;
#(
  parameter int ITER  = 14,
  parameter int GUARD = 3,
  parameter int ANG_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] phase_out,
  output logic [15:0] mag_out,
  output logic        zero_out
);

  localparam int DW = 18 + 2 * GUARD;
  localparam int PW = DW + 14;
  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_e               state_q, state_d;
  logic [3:0]           iter_q, iter_d;
  logic signed [DW-1:0] x_q, x_d;
  logic signed [DW-1:0] y_q, y_d;
  logic [ANG_W-1:0]     z_q, z_d;
  logic                 zero_q, zero_d;
  logic                 zo_q, zo_d;
  logic                 ov_q, ov_d;
  logic                 rdy_q, rdy_d;
  logic [15:0]          ph_q, ph_d;
  logic [15:0]          mag_q, mag_d;

  logic signed [DW-1:0] xe, ye;
  logic signed [DW-1:0] xr, yr;
  logic [ANG_W-1:0]     zr;
  logic signed [PW-1:0] prod, rnd, sh;
  logic [ANG_W-1:0]     zsum;
  logic [10:0]          ph_r;
  logic [15:0]          mag_r;

  cordic_vec_stage #(
    .DW (DW),
    .AW (ANG_W)
  ) u_stage (
    .x_i (x_q),
    .y_i (y_q),
    .z_i (z_q),
    .i_i (iter_q),
    .x_o (xr),
    .y_o (yr),
    .z_o (zr)
  );

  // sign-extend first, then append guard LSBs
  always_comb begin
    xe = {{(2 + GUARD){x_in[15]}}, x_in, {GUARD{1'b0}}};
    ye = {{(2 + GUARD){y_in[15]}}, y_in, {GUARD{1'b0}}};
  end

  // gain compensation, saturation and phase rounding
  always_comb begin
    prod = PW'(x_q) * PW'(K_INV);
    rnd  = prod + (PW'(1) <<< (10 + GUARD));
    sh   = rnd >>> (11 + GUARD);
    if (sh < 0) begin
      mag_r = 16'd0;
    end else if (sh > PW'(65535)) begin
      mag_r = 16'hFFFF;
    end else begin
      mag_r = 16'(sh);
    end
    zsum = z_q + (ANG_W'(1) << (ANG_W - 12));
    ph_r = 11'(zsum >> (ANG_W - 11));
  end

  // FSM next state, capture/pre-fold, iteration and result load
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    zo_d    = zo_q;
    ov_d    = ov_q;
    ph_d    = ph_q;
    mag_d   = mag_q;
    rdy_d   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          zero_d  = (x_in == 16'd0) && (y_in == 16'd0);
          iter_d  = 4'd0;
          state_d = ROT;
          if (x_in[15]) begin
            x_d = -xe;
            y_d = -ye;
            z_d = ANG_W'(1) << (ANG_W - 1);
          end else begin
            x_d = xe;
            y_d = ye;
            z_d = '0;
          end
        end
      end
      ROT: begin
        x_d    = xr;
        y_d    = yr;
        z_d    = zr;
        iter_d = iter_q + 4'd1;
        if (iter_q == LAST) begin
          iter_d  = 4'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!ov_q) begin
          ov_d  = 1'b1;
          zo_d  = zero_q;
          ph_d  = zero_q ? 16'd0 : ({5'd0, ph_r} & PHASE_MASK);
          mag_d = zero_q ? 16'd0 : mag_r;
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= 4'd0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      zo_q    <= 1'b0;
      ov_q    <= 1'b0;
      rdy_q   <= 1'b0;
      ph_q    <= 16'd0;
      mag_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      zo_q    <= zo_d;
      ov_q    <= ov_d;
      rdy_q   <= rdy_d;
      ph_q    <= ph_d;
      mag_q   <= mag_d;
    end
  end

  assign in_ready  = rdy_q && (state_q == IDLE);
  assign out_valid = ov_q;
  assign phase_out = ph_q;
  assign mag_out   = mag_q;
  assign zero_out  = zo_q;

endmodule
